// File: rtl/stack_pointer_ctrl14b.sv
// stack_pointer_ctrl14b: 14-bit downward-growing data-stack pointer with push/pop/load and multi-word alloc/free
// Ports: clk, reset (sync, active-high); push/pop/load/load_val single-cycle IDLE ops;
//        alloc_req/alloc_dir/alloc_cnt start a multi-step adjust, alloc_busy/alloc_done handshake;
//        sp (registered), empty/full (from sp), fault (sticky bound violation).
// Optional: define SPC_BOUNDS_CHECK_EN to suppress out-of-range steps and raise fault; otherwise sp wraps.

module subone14b (
   input  logic [13:0] a,
   output logic [13:0] y
);
   assign y = a - 14'd1;
endmodule

module stack_pointer_ctrl14b #(
   parameter int               WIDTH    = 14,
   parameter logic [WIDTH-1:0] SP_TOP   = 14'h3FFF,
   parameter logic [WIDTH-1:0] SP_LIMIT = 14'h3C00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             alloc_req,
   input  logic             alloc_dir,
   input  logic [7:0]       alloc_cnt,
   output logic             alloc_busy,
   output logic             alloc_done,
   output logic [WIDTH-1:0] sp,
   output logic             empty,
   output logic             full,
   output logic             fault
);
   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
   state_t           state;
   logic             dir;
   logic [7:0]       cnt;
   logic [WIDTH-1:0] sp_dn, sp_up;
   logic             dn_bad, up_bad;
   subone14b u_sub (.a(sp), .y(sp_dn));
   assign sp_up = sp + 1'b1;
   assign empty = sp == SP_TOP;
   assign full  = sp == SP_LIMIT;
`ifdef SPC_BOUNDS_CHECK_EN
   assign dn_bad = full;
   assign up_bad = empty;
`else
   assign dn_bad = 1'b0;
   assign up_bad = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         sp         <= SP_TOP;
         state      <= IDLE;
         alloc_busy <= 1'b0;
         alloc_done <= 1'b0;
         fault      <= 1'b0;
         cnt        <= 8'd0;
         dir        <= 1'b0;
      end else begin
         alloc_done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  sp    <= load_val;
                  fault <= 1'b0;
               end else if (alloc_req) begin
                  dir        <= alloc_dir;
                  cnt        <= alloc_cnt;
                  state      <= (alloc_cnt == 8'd0) ? DONE : STEP;
                  alloc_busy <= alloc_cnt != 8'd0;
                  alloc_done <= alloc_cnt == 8'd0;
               end else if (push && !pop) begin
                  if (dn_bad) fault <= 1'b1;
                  else sp <= sp_dn;
               end else if (pop && !push) begin
                  if (up_bad) fault <= 1'b1;
                  else sp <= sp_up;
               end
            end
            STEP: begin
               // a blocked step ends the transfer early through DONE
               if (dir ? up_bad : dn_bad) begin
                  fault      <= 1'b1;
                  cnt        <= 8'd0;
                  state      <= DONE;
                  alloc_busy <= 1'b0;
                  alloc_done <= 1'b1;
               end else begin
                  sp  <= dir ? sp_up : sp_dn;
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     state      <= DONE;
                     alloc_busy <= 1'b0;
                     alloc_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_pointer_ctrl14b.sv
// tb_stack_pointer_ctrl14b: scoreboard bench, every alloc_done pulse is matched against a queued model expectation
module tb_stack_pointer_ctrl14b;
   localparam logic [13:0] TOP   = 14'h3FFF;
   localparam logic [13:0] LIMIT = 14'h3C00;
`ifdef SPC_BOUNDS_CHECK_EN
   localparam bit BND = 1'b1;
`else
   localparam bit BND = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset, push, pop, load, alloc_req, alloc_dir;
   logic [13:0] load_val;
   logic [7:0]  alloc_cnt;
   logic        alloc_busy, alloc_done, empty, full, fault;
   logic [13:0] sp;
   typedef struct {
      logic [13:0] sp;
      bit          fault;
      int          busy;
   } exp_t;
   exp_t        sb[$];
   logic [13:0] m_sp;
   bit          m_fault;
   int          n_chk = 0, n_pass = 0, busy_ct = 0;

   stack_pointer_ctrl14b dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .load(load), .load_val(load_val),
      .alloc_req(alloc_req), .alloc_dir(alloc_dir), .alloc_cnt(alloc_cnt),
      .alloc_busy(alloc_busy), .alloc_done(alloc_done), .sp(sp),
      .empty(empty), .full(full), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // monitor: each done pulse is one observed transaction
   always @(negedge clk) begin
      exp_t e;
      if (reset) busy_ct = 0;
      else begin
         if (alloc_busy) busy_ct++;
         if (alloc_done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               chk("done_sp", sp, e.sp);
               chk("done_fault", fault, e.fault);
               chk("done_busy_cycles", busy_ct, e.busy);
               chk("done_empty", empty, e.sp == TOP);
               chk("done_full", full, e.sp == LIMIT);
            end
            busy_ct = 0;
         end
      end
   end

   task automatic clear_in();
      push = 0; pop = 0; load = 0; alloc_req = 0; alloc_dir = 0; alloc_cnt = 0; load_val = 0;
   endtask

   task automatic junk();
      push = 1'($urandom); pop = 1'($urandom); load = 1'($urandom);
      load_val = 14'($urandom); alloc_req = 1'($urandom);
      alloc_dir = 1'($urandom); alloc_cnt = 8'($urandom);
   endtask

   task automatic single(bit pu, bit po);
      clear_in();
      push = pu; pop = po;
      @(negedge clk);
      clear_in();
      if (pu != po) begin
         if (pu) begin
            if (BND && m_sp == LIMIT) m_fault = 1;
            else m_sp = m_sp - 14'd1;
         end else begin
            if (BND && m_sp == TOP) m_fault = 1;
            else m_sp = m_sp + 14'd1;
         end
      end
   endtask

   task automatic do_load(logic [13:0] v);
      clear_in();
      load = 1; load_val = v;
      @(negedge clk);
      clear_in();
      m_sp = v; m_fault = 0;
   endtask

   task automatic do_alloc(bit dir, logic [7:0] cnt);
      exp_t e;
      bit got = 0;
      e.busy = 0;
      for (int i = 0; i < cnt; i++) begin
         e.busy++;
         if (BND && (dir ? m_sp == TOP : m_sp == LIMIT)) begin
            m_fault = 1;
            break;
         end
         m_sp = dir ? m_sp + 14'd1 : m_sp - 14'd1;
      end
      e.sp = m_sp; e.fault = m_fault;
      sb.push_back(e);
      clear_in();
      alloc_req = 1; alloc_dir = dir; alloc_cnt = cnt;
      @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         if (alloc_done) begin
            got = 1;
            break;
         end
         junk();
         @(negedge clk);
      end
      if (!got) chk("done_timeout", 0, 1);
      junk();
      @(negedge clk);
      clear_in();
   endtask

   task automatic probe();
      do_alloc(0, 8'd0);
   endtask

   initial begin
      int r;
      clear_in();
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      m_sp = TOP; m_fault = 0;
      chk("rst_sp", sp, 14'h3FFF);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_fault", fault, 0);
      chk("rst_busy", alloc_busy, 0);
      chk("rst_done", alloc_done, 0);
      repeat (3) single(1, 0);
      single(0, 1);
      probe();
      single(1, 1);
      probe();
      do_load(TOP);
      do_alloc(0, 8'd5);
      do_alloc(1, 8'd5);
      probe();
      do_load(14'h3C01);
      do_alloc(0, 8'd4);
      do_load(14'h3C00);
      single(1, 0);
      probe();
      do_load(14'h0000);
      single(1, 0);
      probe();
      do_load(TOP);
      single(0, 1);
      probe();
      // reset in the middle of a transfer: no done pulse may follow
      clear_in();
      alloc_req = 1; alloc_dir = 0; alloc_cnt = 8'd10;
      @(negedge clk);
      clear_in();
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      m_sp = TOP; m_fault = 0;
      repeat (12) @(negedge clk);
      probe();
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 9);
         if (r < 5) single(1'($urandom), 1'($urandom));
         else if (r == 5) begin
            case ($urandom_range(0, 4))
               0: do_load(TOP);
               1: do_load(LIMIT);
               2: do_load(LIMIT + 14'd2);
               3: do_load(TOP - 14'd3);
               default: do_load(14'($urandom));
            endcase
         end else if (r < 8) do_alloc(1'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20)));
         else probe();
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
